// File: rtl/omsp_gfx_pkg.sv
// Shared definitions for the graphic controller LT24 refresh path:
// FSM state encoding, LCD command opcodes and the window-address word table.
package omsp_gfx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_PIX_REQ,
    ST_PIX_WAIT,
    ST_PIX_WR,
    ST_DONE
  } lt24_state_e;

  localparam logic [7:0] LT24_CMD_CASET = 8'h2A;
  localparam logic [7:0] LT24_CMD_PASET = 8'h2B;
  localparam logic [7:0] LT24_CMD_RAMWR = 8'h2C;

  // One bus write: register-select plus the 16-bit bus value
  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } lt24_word_t;

  // Address-window sequence: cmd, 0x00, 0x00, (extent-1)[15:8], (extent-1)[7:0].
  // The start address is always 0; extent-1 wraps modulo 2^16.
  function automatic lt24_word_t lt24_win_word(input logic [2:0]  idx,
                                               input logic [7:0]  cmd,
                                               input logic [15:0] extent);
    logic [15:0] last;
    lt24_word_t  w;
    last = extent - 16'd1;
    case (idx)
      3'd0:        w = '{rs: 1'b0, data: {8'h00, cmd}};
      3'd1, 3'd2:  w = '{rs: 1'b1, data: 16'h0000};
      3'd3:        w = '{rs: 1'b1, data: {8'h00, last[15:8]}};
      default:     w = '{rs: 1'b1, data: {8'h00, last[7:0]}};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/omsp_gfx_if_lt24_wr.sv
// LT24 bus write strobe generator: one write is N cycles of wr_n low followed
// by N cycles of wr_n high (N = cfg+1). rs/d are launched with the falling
// edge and held. 'done' flags the last high cycle so a following write can
// start back-to-back on the same edge.
module omsp_gfx_if_lt24_wr (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rs_sel,
  input  logic [15:0] data,
  input  logic [2:0]  cfg,
  output logic        wr_n,
  output logic [15:0] d,
  output logic        rs,
  output logic        busy,
  output logic        done
);

  logic [2:0] cnt;
  logic       high;

  assign done = busy & high & (cnt == cfg);

  // Phase counter: low phase, then high phase, each cfg+1 cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      high <= 1'b0;
      cnt  <= 3'd0;
      wr_n <= 1'b1;
      d    <= 16'h0000;
      rs   <= 1'b1;
    end else if (start) begin
      busy <= 1'b1;
      high <= 1'b0;
      cnt  <= 3'd0;
      wr_n <= 1'b0;
      d    <= data;
      rs   <= rs_sel;
    end else if (busy) begin
      if (cnt == cfg) begin
        cnt <= 3'd0;
        if (!high) begin
          high <= 1'b1;
          wr_n <= 1'b1;
        end else begin
          busy <= 1'b0;
          high <= 1'b0;
        end
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/omsp_gfx_if_lt24.sv
// LT24 display refresh engine: opens the address window (optional), issues
// Memory Write, then streams display_size_i pixels fetched one at a time from
// the backend, and pulses refresh_done_evt_o at the end of the frame.
// Optional feature macro: OMSP_GFX_LT24_WINDOW_EN (CASET/PASET before each frame).
module omsp_gfx_if_lt24
  import omsp_gfx_pkg::*;
(
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [15:0] display_width_i,
  input  logic [15:0] display_height_i,
  input  logic [31:0] display_size_i,
  input  logic [2:0]  lt24_cfg_clk_i,
  input  logic        refresh_start_i,
  input  logic [15:0] refresh_data_i,
  input  logic        refresh_data_ready_i,
  output logic        refresh_data_request_o,
  output logic        refresh_active_o,
  output logic        refresh_done_evt_o,
  output logic        lt24_cs_n_o,
  output logic        lt24_rs_o,
  output logic        lt24_wr_n_o,
  output logic        lt24_rd_n_o,
  output logic [15:0] lt24_d_o,
  output logic        lt24_d_en_o
);

  lt24_state_e state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [31:0] pix_cnt, pix_cnt_nxt;
  logic        wr_start;
  lt24_word_t  wr_word;
  logic        wr_done;
  logic        unused_wr_busy;   // FSM state already tells whether a write is in flight
  logic        frame_nxt;

`ifndef OMSP_GFX_LT24_WINDOW_EN
  // Window extents only matter when the address window is programmed
  logic unused_dims;
  assign unused_dims = ^{display_width_i, display_height_i};
`endif

  assign lt24_rd_n_o = 1'b1;
  assign frame_nxt   = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);

  // Next-state, command sequencing and write launch
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pix_cnt_nxt = pix_cnt;
    wr_start    = 1'b0;
    wr_word     = '{rs: 1'b1, data: 16'h0000};
    case (state)
      ST_IDLE: begin
        if (refresh_start_i) begin
          wr_start = 1'b1;
`ifdef OMSP_GFX_LT24_WINDOW_EN
          wr_word   = lt24_win_word(3'd0, LT24_CMD_CASET, display_width_i);
          idx_nxt   = 3'd1;
          state_nxt = ST_CASET;
`else
          wr_word   = '{rs: 1'b0, data: {8'h00, LT24_CMD_RAMWR}};
          state_nxt = ST_RAMWR;
`endif
        end
      end
`ifdef OMSP_GFX_LT24_WINDOW_EN
      // idx counts words already launched; 5 means the group is complete
      ST_CASET: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx == 3'd5) begin
            wr_word   = lt24_win_word(3'd0, LT24_CMD_PASET, display_height_i);
            idx_nxt   = 3'd1;
            state_nxt = ST_PASET;
          end else begin
            wr_word = lt24_win_word(idx, LT24_CMD_CASET, display_width_i);
            idx_nxt = idx + 3'd1;
          end
        end
      end
      ST_PASET: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx == 3'd5) begin
            wr_word   = '{rs: 1'b0, data: {8'h00, LT24_CMD_RAMWR}};
            idx_nxt   = 3'd0;
            state_nxt = ST_RAMWR;
          end else begin
            wr_word = lt24_win_word(idx, LT24_CMD_PASET, display_height_i);
            idx_nxt = idx + 3'd1;
          end
        end
      end
`endif
      ST_RAMWR: begin
        if (wr_done) begin
          if (display_size_i == 32'd0) begin
            state_nxt = ST_DONE;
          end else begin
            pix_cnt_nxt = display_size_i;
            state_nxt   = ST_PIX_REQ;
          end
        end
      end
      // A ready coinciding with the request cycle is taken immediately
      ST_PIX_REQ, ST_PIX_WAIT: begin
        if (refresh_data_ready_i) begin
          wr_start  = 1'b1;
          wr_word   = '{rs: 1'b1, data: refresh_data_i};
          state_nxt = ST_PIX_WR;
        end else begin
          state_nxt = ST_PIX_WAIT;
        end
      end
      // Next pixel is only requested once the current write has fully completed
      ST_PIX_WR: begin
        if (wr_done) begin
          pix_cnt_nxt = pix_cnt - 32'd1;
          state_nxt   = (pix_cnt == 32'd1) ? ST_DONE : ST_PIX_REQ;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered frame-level outputs, all derived from next state
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state                  <= ST_IDLE;
      idx                    <= 3'd0;
      pix_cnt                <= 32'd0;
      refresh_active_o       <= 1'b0;
      lt24_cs_n_o            <= 1'b1;
      lt24_d_en_o            <= 1'b0;
      refresh_data_request_o <= 1'b0;
      refresh_done_evt_o     <= 1'b0;
    end else begin
      state                  <= state_nxt;
      idx                    <= idx_nxt;
      pix_cnt                <= pix_cnt_nxt;
      refresh_active_o       <= frame_nxt;
      lt24_cs_n_o            <= ~frame_nxt;
      lt24_d_en_o            <= frame_nxt;
      refresh_data_request_o <= (state_nxt == ST_PIX_REQ);
      refresh_done_evt_o     <= (state_nxt == ST_DONE);
    end
  end

  omsp_gfx_if_lt24_wr u_wr (
    .clk    (mclk),
    .rst    (puc_rst),
    .start  (wr_start),
    .rs_sel (wr_word.rs),
    .data   (wr_word.data),
    .cfg    (lt24_cfg_clk_i),
    .wr_n   (lt24_wr_n_o),
    .d      (lt24_d_o),
    .rs     (lt24_rs_o),
    .busy   (unused_wr_busy),
    .done   (wr_done)
  );

endmodule

// File: tb/tb_omsp_gfx_if_lt24.sv
// Bench for omsp_gfx_if_lt24: a frame timeline model is built from the bus
// timing rules (writes of 2N cycles, request + latency + write per pixel) and
// compared against the DUT outputs on every cycle of each frame.
// Honours OMSP_GFX_LT24_WINDOW_EN the same way the design does.
module tb_omsp_gfx_if_lt24;

  localparam int TMAX = 1024;
  localparam logic [6:0] IDLE_V = 7'b0101001;  // {active,cs_n,d_en,wr_n,req,done,rd_n}

`ifdef OMSP_GFX_LT24_WINDOW_EN
  localparam int NCMD = 11;
  localparam int T_F1 = 55, T_F2 = 116, T_F3 = 23;
  logic [16:0] lit_w [NCMD] = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000, 17'h10003,
                                17'h0002B, 17'h10000, 17'h10000, 17'h10000, 17'h10001,
                                17'h0002C};
`else
  localparam int NCMD = 1;
  localparam int T_F1 = 35, T_F2 = 36, T_F3 = 3;
  logic [16:0] lit_w [NCMD] = '{17'h0002C};
`endif

  logic        mclk, puc_rst;
  logic [15:0] display_width_i, display_height_i;
  logic [31:0] display_size_i;
  logic [2:0]  lt24_cfg_clk_i;
  logic        refresh_start_i;
  logic [15:0] refresh_data_i;
  logic        refresh_data_ready_i;
  logic        refresh_data_request_o, refresh_active_o, refresh_done_evt_o;
  logic        lt24_cs_n_o, lt24_rs_o, lt24_wr_n_o, lt24_rd_n_o, lt24_d_en_o;
  logic [15:0] lt24_d_o;

  omsp_gfx_if_lt24 dut (
    .mclk                   (mclk),
    .puc_rst                (puc_rst),
    .display_width_i        (display_width_i),
    .display_height_i       (display_height_i),
    .display_size_i         (display_size_i),
    .lt24_cfg_clk_i         (lt24_cfg_clk_i),
    .refresh_start_i        (refresh_start_i),
    .refresh_data_i         (refresh_data_i),
    .refresh_data_ready_i   (refresh_data_ready_i),
    .refresh_data_request_o (refresh_data_request_o),
    .refresh_active_o       (refresh_active_o),
    .refresh_done_evt_o     (refresh_done_evt_o),
    .lt24_cs_n_o            (lt24_cs_n_o),
    .lt24_rs_o              (lt24_rs_o),
    .lt24_wr_n_o            (lt24_wr_n_o),
    .lt24_rd_n_o            (lt24_rd_n_o),
    .lt24_d_o               (lt24_d_o),
    .lt24_d_en_o            (lt24_d_en_o)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  int checks = 0;
  int errors = 0;

  // model state
  logic [6:0]  ev   [TMAX];
  logic [16:0] ew   [TMAX];
  bit          ew_v [TMAX];
  logic [16:0] wq [$];
  int          t_end;
  int          lat [16];
  logic [15:0] pix [16];

  // monitor handshake (each variable has a single writer)
  int arm_req = 0, arm_seen = 0, mt = 0, frames_done = 0;
  bit running = 0, mon_kill = 0;
  int be_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected frame timeline, cycle 0 = cycle in which start is presented
  task automatic build(input int cfg, input logic [15:0] w, input logic [15:0] h, input int size);
    int n, t, ncw;
    logic [15:0] wm, hm;
    n  = cfg + 1;
    wm = w - 16'd1;
    hm = h - 16'd1;
    for (int i = 0; i < TMAX; i++) begin
      ev[i] = IDLE_V; ew[i] = '0; ew_v[i] = 1'b0;
    end
    wq.delete();
`ifdef OMSP_GFX_LT24_WINDOW_EN
    wq.push_back({1'b0, 16'h002A}); wq.push_back({1'b1, 16'h0000}); wq.push_back({1'b1, 16'h0000});
    wq.push_back({1'b1, 8'h00, wm[15:8]}); wq.push_back({1'b1, 8'h00, wm[7:0]});
    wq.push_back({1'b0, 16'h002B}); wq.push_back({1'b1, 16'h0000}); wq.push_back({1'b1, 16'h0000});
    wq.push_back({1'b1, 8'h00, hm[15:8]}); wq.push_back({1'b1, 8'h00, hm[7:0]});
`endif
    wq.push_back({1'b0, 16'h002C});
    ncw = wq.size();
    for (int i = 0; i < size; i++) wq.push_back({1'b1, pix[i]});
    t = 1;
    for (int k = 0; k < wq.size(); k++) begin
      if (k >= ncw) begin
        ev[t][2] = 1'b1;
        t += lat[k - ncw] + 1;
      end
      for (int j = 0; j < 2 * n; j++) begin
        ew_v[t + j] = 1'b1;
        ew[t + j]   = wq[k];
        if (j < n) ev[t + j][3] = 1'b0;
      end
      t += 2 * n;
    end
    ev[t][1] = 1'b1;
    t_end = t;
    for (int i = 1; i < t; i++) begin
      ev[i][6] = 1'b1; ev[i][5] = 1'b0; ev[i][4] = 1'b1;
    end
  endtask

  task automatic set_lat(input int base, input int stall_idx, input int stall_l);
    for (int i = 0; i < 16; i++) begin
      lat[i] = base;
      pix[i] = 16'($urandom);
    end
    if (stall_idx >= 0) lat[stall_idx] = stall_l;
  endtask

  task automatic arm(input int cfg, input int w, input int h, input int size);
    lt24_cfg_clk_i   = 3'(cfg);
    display_width_i  = 16'(w);
    display_height_i = 16'(h);
    display_size_i   = 32'(size);
    build(cfg, 16'(w), 16'(h), size);
    @(posedge mclk); #1;
    refresh_start_i = 1'b1;
    arm_req++;
    @(posedge mclk); #1;
    refresh_start_i = 1'b0;
  endtask

  task automatic wait_frame(input string nm, input int fd0);
    int i;
    i = 0;
    while (frames_done == fd0 && i < 5000) begin
      @(posedge mclk); i++;
    end
    chk({nm, "_complete"}, 32'(frames_done - fd0), 32'd1);
  endtask

  // Per-cycle comparison of DUT outputs against the frame timeline
  initial begin
    forever begin
      @(negedge mclk);
      if (arm_req != arm_seen) begin
        arm_seen = arm_req; mt = 0; running = 1'b1;
      end else if (running) begin
        mt++;
      end
      if (running && mon_kill) begin
        running = 1'b0;
      end else if (running) begin
        chk($sformatf("bus_ctrl@%0d", mt),
            32'({refresh_active_o, lt24_cs_n_o, lt24_d_en_o, lt24_wr_n_o,
                 refresh_data_request_o, refresh_done_evt_o, lt24_rd_n_o}),
            32'(ev[mt]));
        if (ew_v[mt]) chk($sformatf("bus_word@%0d", mt), 32'({lt24_rs_o, lt24_d_o}), 32'(ew[mt]));
        if (mt >= t_end + 2 || mt >= TMAX - 1) begin
          running = 1'b0;
          frames_done++;
        end
      end
    end
  end

  // Backend: answers each request after the per-pixel latency
  initial begin
    int l;
    refresh_data_ready_i = 1'b0;
    refresh_data_i       = 16'h0000;
    forever begin
      @(negedge mclk);
      if (refresh_start_i && !refresh_active_o) be_idx = 0;
      if (refresh_data_request_o && !puc_rst) begin
        l = (be_idx < 16) ? lat[be_idx] : 0;
        repeat (l) @(negedge mclk);
        refresh_data_i       = (be_idx < 16) ? pix[be_idx] : 16'hDEAD;
        refresh_data_ready_i = 1'b1;
        be_idx++;
        @(negedge mclk);
        refresh_data_ready_i = 1'b0;
      end
    end
  end

  initial begin
    int fd0, i, nreq, nq;
    puc_rst          = 1'b1;
    refresh_start_i  = 1'b0;
    display_width_i  = 16'd0;
    display_height_i = 16'd0;
    display_size_i   = 32'd0;
    lt24_cfg_clk_i   = 3'd0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("reset_ctrl", 32'({lt24_cs_n_o, lt24_rs_o, lt24_wr_n_o, lt24_rd_n_o, lt24_d_en_o,
                           refresh_data_request_o, refresh_active_o, refresh_done_evt_o}),
        32'h000000F0);
    chk("reset_d", 32'(lt24_d_o), 32'h0);
    @(posedge mclk); #1 puc_rst = 1'b0;

    // full frame, small display
    set_lat(1, -1, 0);
    fd0 = frames_done;
    arm(0, 4, 2, 8);
    chk("model_t_end_f1", 32'(t_end), 32'(T_F1));
    for (int k = 0; k < NCMD; k++) chk($sformatf("model_cmd%0d", k), 32'(wq[k]), 32'(lit_w[k]));
    nq = 0;
    for (int k = 0; k <= t_end; k++) nq += int'(ev[k][2]);
    chk("model_req_count", 32'(nq), 32'd8);
    wait_frame("f1", fd0);

    // strobe timing with cfg=3, zero backend latency
    set_lat(0, -1, 0);
    fd0 = frames_done;
    arm(3, 320, 240, 3);
    chk("model_t_end_f2", 32'(t_end), 32'(T_F2));
    wait_frame("f2", fd0);

    // zero-size frame, width 0 wraps to 0xFFFF
    set_lat(0, -1, 0);
    fd0 = frames_done;
    arm(0, 0, 1, 0);
    chk("model_t_end_f3", 32'(t_end), 32'(T_F3));
    wait_frame("f3", fd0);

    // backend stall on the third pixel
    set_lat(2, 2, 20);
    fd0 = frames_done;
    arm(1, 16, 8, 6);
    wait_frame("stall", fd0);

    // start pulses while busy are ignored
    set_lat(0, -1, 0);
    fd0 = frames_done;
    arm(0, 8, 8, 5);
    foreach (lit_w[k]) begin end
    for (int p = 0; p < 2; p++) begin
      i = 0;
      while (mt < (p == 0 ? 2 : 14) && i < 500) begin @(posedge mclk); i++; end
      #1 refresh_start_i = 1'b1;
      @(posedge mclk); #1 refresh_start_i = 1'b0;
    end
    wait_frame("busy_start", fd0);

    // reset in the middle of the pixel phase
    set_lat(1, -1, 0);
    arm(0, 4, 2, 8);
    i = 0;
    while (mt < 30 && i < 500) begin @(posedge mclk); i++; end
    chk("rst_mid_reached", 32'(mt >= 30), 32'd1);
    #1;
    mon_kill = 1'b1;
    puc_rst  = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    chk("rst_mid_bus", 32'({lt24_cs_n_o, lt24_wr_n_o, lt24_d_en_o, refresh_active_o,
                            refresh_data_request_o}), 32'b11000);
    @(posedge mclk); #1 puc_rst = 1'b0;
    nreq = 0;
    repeat (30) begin
      @(negedge mclk);
      nreq += int'(refresh_data_request_o);
    end
    chk("rst_mid_no_req", 32'(nreq), 32'd0);
    mon_kill = 1'b0;

    // new frame after reset runs from the command phase
    set_lat(1, -1, 0);
    fd0 = frames_done;
    arm(0, 4, 2, 8);
    wait_frame("after_rst", fd0);

    repeat (4) @(posedge mclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
